// File: rtl/dk_pkg.sv
// Shared types and screen constants for the DK motion logic and its sprite helpers.
package dk_pkg;

    localparam int POS_W = 16;

    localparam logic [POS_W-1:0] DK_X_MIN   = 16'd0;
    localparam logic [POS_W-1:0] DK_X_MAX   = 16'd620;
    localparam logic [POS_W-1:0] DK_X_RESET = 16'd10;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_t;

endpackage

// File: rtl/dk_hclamp.sv
// Combinational saturating step along the horizontal axis.
// Zero latency; there is no backpressure. Left and right together, or neither, leave the position unchanged.
module dk_hclamp
    import dk_pkg::*;
#(
    parameter logic [POS_W-1:0] X_MIN = DK_X_MIN,
    parameter logic [POS_W-1:0] X_MAX = DK_X_MAX,
    parameter logic [POS_W-1:0] STEP  = 16'd2
) (
    input  logic [POS_W-1:0] pos_i,
    input  logic             left_i,
    input  logic             right_i,
    output logic [POS_W-1:0] pos_o
);

    logic [POS_W:0] sum_up;
    logic [POS_W:0] floor_lo;

    // Compare in 17 bits so that the position can never wrap.
    assign sum_up   = {1'b0, pos_i} + {1'b0, STEP};
    assign floor_lo = {1'b0, X_MIN} + {1'b0, STEP};

    always_comb begin
        pos_o = pos_i;
        if (right_i && !left_i) begin
            pos_o = (sum_up > {1'b0, X_MAX}) ? X_MAX : sum_up[POS_W-1:0];
        end else if (left_i && !right_i) begin
            pos_o = ({1'b0, pos_i} < floor_lo) ? X_MIN : pos_i - STEP;
        end
    end

endmodule

// File: rtl/dk_motion_ctrl.sv
// Per-frame player motion: horizontal clamp plus jump FSM with gravity; outputs are registered.
// Each result appears one cycle after a frame_tick. There is no backpressure, and every register holds between ticks.
module dk_motion_ctrl
    import dk_pkg::*;
#(
    parameter logic [POS_W-1:0] X_MIN   = DK_X_MIN,
    parameter logic [POS_W-1:0] X_MAX   = DK_X_MAX,
    parameter logic [POS_W-1:0] X_RESET = DK_X_RESET,
    parameter logic [POS_W-1:0] STEP    = 16'd2,
    parameter logic [POS_W-1:0] JUMP_V0 = 16'd12,
    parameter logic [POS_W-1:0] GRAVITY = 16'd1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_jump,
    output logic [POS_W-1:0] bigD,
    output logic [POS_W-1:0] smallD,
    output logic             in_air,
    output logic [1:0]       jump_state
);

    jump_state_t      state_q, state_d;
    logic [POS_W-1:0] vel_q, vel_d;
    logic [POS_W-1:0] small_q, small_d;
    logic [POS_W-1:0] big_q, big_d;
    logic             armed_q, armed_d;
    logic [POS_W-1:0] big_next;
    logic [POS_W-1:0] vel_fall;

    dk_hclamp #(
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .STEP  (STEP)
    ) u_hclamp (
        .pos_i   (big_q),
        .left_i  (key_left),
        .right_i (key_right),
        .pos_o   (big_next)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= GROUND;
            vel_q   <= '0;
            small_q <= '0;
            big_q   <= X_RESET;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            vel_q   <= vel_d;
            small_q <= small_d;
            big_q   <= big_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vel_d    = vel_q;
        small_d  = small_q;
        big_d    = big_q;
        armed_d  = armed_q;
        vel_fall = vel_q + GRAVITY;
        if (frame_tick) begin
            big_d = big_next;
            if (!key_jump) begin
                armed_d = 1'b1;
            end
            case (state_q)
                GROUND: begin
                    // smallD stays at 0 on the launch tick; the first rise step comes on the next tick.
                    if (key_jump && armed_q) begin
                        state_d = RISE;
                        vel_d   = JUMP_V0;
                        armed_d = 1'b0;
                    end else begin
                        small_d = '0;
                    end
                end
                RISE: begin
                    small_d = small_q + vel_q;
                    if (vel_q <= GRAVITY) begin
                        vel_d   = '0;
                        state_d = FALL;
                    end else begin
                        vel_d = vel_q - GRAVITY;
                    end
                end
                FALL: begin
                    if (small_q <= vel_fall) begin
                        small_d = '0;
                        vel_d   = '0;
                        state_d = GROUND;
                    end else begin
                        small_d = small_q - vel_fall;
                        vel_d   = vel_fall;
                    end
                end
                default: begin
                    state_d = GROUND;
                    small_d = '0;
                    vel_d   = '0;
                end
            endcase
        end
    end

    assign bigD       = big_q;
    assign smallD     = small_q;
    assign jump_state = state_q;
    assign in_air     = (state_q == RISE) || (state_q == FALL);

endmodule

// File: tb/tb_dk_motion_ctrl.sv
// Directed and randomized bench for dk_motion_ctrl, with JUMP_V0=4 and GRAVITY=1.
module tb_dk_motion_ctrl;

    localparam int V0 = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic        key_left;
    logic        key_right;
    logic        key_jump;
    logic [15:0] bigD;
    logic [15:0] smallD;
    logic        in_air;
    logic [1:0]  jump_state;

    dk_motion_ctrl #(
        .JUMP_V0 (16'd4),
        .GRAVITY (16'd1)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_jump   (key_jump),
        .bigD       (bigD),
        .smallD     (smallD),
        .in_air     (in_air),
        .jump_state (jump_state)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference model: the jump is a precomputed list of (height, state) pairs that is consumed one entry per tick.
    int m_x;
    int m_h;
    int m_st;
    bit m_armed;
    int q_h[$];
    int q_st[$];

    function automatic int height(int i);
        return i * V0 - (i * (i - 1)) / 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bigD"}, 32'(bigD), m_x);
        chk({tag, ".smallD"}, 32'(smallD), m_h);
        chk({tag, ".state"}, 32'(jump_state), m_st);
        chk({tag, ".in_air"}, 32'(in_air), (m_st != 0) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_x = 10;
        m_h = 0;
        m_st = 0;
        m_armed = 1'b1;
        q_h.delete();
        q_st.delete();
    endtask

    task automatic model_tick(input bit l, input bit r, input bit j);
        if (l ^ r) begin
            if (r) m_x = (m_x + 2 > 620) ? 620 : m_x + 2;
            else   m_x = (m_x < 2) ? 0 : m_x - 2;
        end
        if (!j) m_armed = 1'b1;
        if (q_h.size() == 0) begin
            if (j && m_armed) begin
                m_armed = 1'b0;
                m_st = 1;
                for (int i = 1; i <= V0; i++) begin
                    q_h.push_back(height(i));
                    q_st.push_back((i == V0) ? 2 : 1);
                end
                for (int k = 1; k <= V0; k++) begin
                    q_h.push_back(height(V0 - k));
                    q_st.push_back((k == V0) ? 0 : 2);
                end
            end else begin
                m_h = 0;
                m_st = 0;
            end
        end else begin
            m_h = q_h.pop_front();
            m_st = q_st.pop_front();
        end
    endtask

    task automatic step(input bit l, input bit r, input bit j, input bit tk, input string tag);
        @(negedge Clk);
        key_left = l;
        key_right = r;
        key_jump = j;
        frame_tick = tk;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
        if (tk) model_tick(l, r, j);
        check_all(tag);
    endtask

    initial begin
        int arc_h[9];
        int arc_s[9];
        arc_h = '{0, 4, 7, 9, 10, 9, 7, 4, 0};
        arc_s = '{1, 1, 1, 1, 2, 2, 2, 2, 0};

        Reset = 1'b0;
        frame_tick = 1'b0;
        key_left = 1'b0;
        key_right = 1'b0;
        key_jump = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, "idle");

        for (int i = 0; i < 400; i++) step(0, 1, 0, 1, "right");
        chk("right_sat", 32'(bigD), 620);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, "both");

        @(negedge Clk);
        Reset = 1'b0;
        #1;
        model_reset();
        check_all("reset2");
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1, "left");
        chk("left_floor", 32'(bigD), 0);

        // Jump arc checked against literal heights and states, as well as the model.
        step(0, 0, 1, 1, "jump_go");
        chk("arc_h0", 32'(smallD), arc_h[0]);
        chk("arc_s0", 32'(jump_state), arc_s[0]);
        for (int k = 1; k < 9; k++) begin
            step(0, 0, 0, 1, "arc");
            chk("arc_h", 32'(smallD), arc_h[k]);
            chk("arc_s", 32'(jump_state), arc_s[k]);
        end

        // Jump held through the full arc: exactly one jump.
        for (int i = 0; i < 14; i++) step(0, 0, 1, 1, "held");
        chk("held_ground", 32'(jump_state), 0);
        step(0, 0, 0, 1, "release");
        step(0, 0, 1, 1, "repress");
        chk("repress_rise", 32'(jump_state), 1);

        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, "land");
        step(0, 1, 1, 1, "jump2");
        step(0, 1, 0, 1, "jump2");
        step(0, 1, 0, 1, "jump2");
        chk("mid_h7", 32'(smallD), 7);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 100; i++) step(0, 1, 1, 0, "gated");

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dk_motion_ctrl.md
Name: dk_motion_ctrl

Overview:
Per-frame motion generator for the player character. It converts held key inputs into the next horizontal position (bigD) and the next vertical jump offset (smallD). It updates once per frame tick and feeds the DK position register stage directly downstream. It owns the jump state machine, gravity integration and screen-edge clamping.

Parameters:
X_MIN, 16'd0, leftmost legal horizontal position
X_MAX, 16'd620, rightmost legal horizontal position
X_RESET, 16'd10, horizontal position after reset (matches the downstream register reset value)
STEP, 16'd2, horizontal pixels moved per frame tick
JUMP_V0, 16'd12, initial upward velocity at jump start
GRAVITY, 16'd1, velocity change per frame tick while airborne

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse per frame (vsync-derived); all state advances only on this cycle
key_left  in  1  move-left held
key_right  in  1  move-right held
key_jump  in  1  jump held
bigD  out  16  next horizontal position, unsigned, to downstream register
smallD  out  16  next vertical offset above ground, unsigned, 0 = on ground
in_air  out  1  high while the state is RISE or FALL
jump_state  out  2  encoded FSM state, for debug and sprite select

Behaviour:
- Reset (Reset==0, asynchronous, including mid-jump): bigD=X_RESET, smallD=0, vel=0, state=GROUND, in_air=0, jump_armed=1.
- All outputs are registered. Updates happen only on a rising Clk edge with frame_tick=1. The new value is visible the cycle after the tick. With frame_tick=0, every register holds.
- Horizontal movement, evaluated every tick in any state:
  - key_left XOR key_right is required to move. Both held or neither held: bigD holds.
  - Right: bigD = (bigD+STEP > X_MAX) ? X_MAX : bigD+STEP.
  - Left: bigD = (bigD < X_MIN+STEP) ? X_MIN : bigD-STEP.
  - No wrap-around. Intermediate sums are 17 bits.
- jump_armed:
  - Cleared when a jump starts.
  - Set on any tick where key_jump=0.
  - Holding jump through a landing does not retrigger; the key must be released for at least one tick.
- FSM, with internal 16-bit vel:
  - GROUND: if key_jump && jump_armed, go to RISE with vel=JUMP_V0 and smallD unchanged this tick. Otherwise stay, with smallD=0.
  - RISE: smallD += vel, then vel -= GRAVITY. If the decremented vel == 0 (or GRAVITY > vel), set vel=0 and go to FALL.
  - FALL: vel += GRAVITY. If smallD <= new vel, set smallD=0 and vel=0 and go to GROUND (landing tick). Otherwise smallD -= new vel.
  - key_jump is ignored in RISE and FALL, apart from arming.
- Horizontal and vertical updates on the same tick are independent and both apply.
- The trajectory is symmetric: peak offset = sum of JUMP_V0 down to 1. The default peak is 78.
- jump_state encoding: GROUND=0, RISE=1, FALL=2. The value 3 is illegal and recovers to GROUND with smallD=0 on the next tick.

Decomposition:
- Shared package dk_pkg holds:
  - the jump_state_t enum (GROUND, RISE, FALL);
  - the position width constant POS_W=16;
  - the default screen bounds X_MIN, X_MAX and X_RESET.
- One natural sub-module: dk_hclamp, a combinational saturating add/subtract for the horizontal axis, reusable for enemy sprites.
- The FSM and vel registers stay in the top.

Test Plan:
- Reset and hold: assert Reset=0 mid-sim, release, hold all keys idle and issue 5 ticks -> bigD=10, smallD=0, in_air=0 throughout; no change between ticks.
- Right clamp: start bigD=10, key_right held for 400 ticks -> bigD increases by 2 per tick and saturates at 620; key_left and key_right both held -> bigD unchanged.
- Left clamp: key_left from reset -> bigD goes 10→8→6→4→2→0 and stays 0; no wrap to 0xFFFE.
- Jump arc, overriding JUMP_V0=4 and GRAVITY=1: key_jump pulsed for 1 tick, then released:
  - smallD per tick: 0 (start), 4, 7, 9, 10, 9, 7, 4, 0;
  - state goes RISE to FALL after 10, and to GROUND at 0;
  - in_air falls on the landing tick.
- Held jump: key_jump held continuously through the full arc -> exactly one jump; no new RISE until key_jump is low for at least one tick, then the next press starts a jump.
- Reset mid-jump, plus tick gating: assert Reset=0 asynchronously between clock edges while smallD=7 -> outputs return to reset values immediately. Separately, frame_tick=0 for 100 cycles with keys held -> no output change.
